vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock produced by the clock divider stage. It supplies pixel coordinates and a pixel request to the maze renderer. It also outputs hsync, vsync and display-enable, delayed to line up with the renderer's pipelined colour output. It sits between the clock divider and the VGA pins / renderer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- PIPE_DLY, 2, renderer latency in clocks; legal range 1..4

Ports:
- clk  in  1  pixel clock, 25 MHz, from clock divider
- rst  in  1  reset, asynchronous, active-high
- pix_x  out  10  current horizontal count (0..799), undelayed
- pix_y  out  10  current vertical count (0..524), undelayed
- pix_req  out  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE, undelayed
- sof  out  1  one-cycle pulse when pix_x==0 and pix_y==0
- hs  out  1  horizontal sync, delayed PIPE_DLY
- vs  out  1  vertical sync, delayed PIPE_DLY
- de  out  1  display enable, delayed PIPE_DLY

## Operation
- Counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - v_cnt counts 0..V_TOTAL-1, where V_TOTAL = 525.
  - Both counters are 10-bit registers.
- h_cnt wraps from 799 to 0. v_cnt increments only on that h_cnt wrap cycle.
- v_cnt wraps from 524 to 0 on the same cycle h_cnt wraps from 799.
- pix_x and pix_y are the counter registers themselves.
- pix_req and sof are decoded combinationally from the counter registers.
- Raw sync decode:
  - hs_raw is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - vs_raw is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491].
  - de_raw equals pix_req.
- Active level is SYNC_POL. The inactive level is ~SYNC_POL.
- {hs_raw, vs_raw, de_raw} pass through a PIPE_DLY-stage register chain. Chain outputs drive hs/vs/de.
- Reset values:
  - h_cnt = 0, v_cnt = 0, so pix_req = 1 and sof = 1 while rst is held.
  - Every delay stage is loaded with hs/vs at the inactive level and de = 0.
  - hs and vs are therefore at the inactive level and de = 0 during reset.
- Reset mid-frame: counters and delay chain clear asynchronously. No partial line is completed. Counting restarts from (0,0) on the first clk edge after rst deasserts.
- Illegal PIPE_DLY (0 or >4) is a configuration error. It is flagged by an elaboration-time check; no runtime behaviour is defined.

## Timing
- While rst is deasserted, the counters advance every clk edge. There is no stall input.
- Line period: 800 clocks. Frame period: 420000 clocks, i.e. 59.52 Hz at 25.0 MHz.
- hs, vs and de at edge t+PIPE_DLY reflect the counter value present at edge t.
- The renderer must present colour for (pix_x, pix_y) exactly PIPE_DLY clocks after pix_req.
- hs active length: 96 clocks per line. vs active length: 1600 clocks per frame.
- Both vs edges coincide with h_cnt = 0 in the undelayed domain.
- sof is high for exactly one clock per frame, while (0,0) is held. The exception is during reset, when it is held high.

## Structure
- Shared package vga_pkg holds:
  - the 640x480 timing constants;
  - H_TOTAL and V_TOTAL;
  - the counter width constant (10).
  The maze renderer reuses the same package for coordinate widths.
- One sub-module: sync_delay_line.
  - A parameterised shift register with WIDTH=3 and DEPTH=PIPE_DLY.
  - It takes a per-bit reset value vector, so hs and vs reset inactive and de resets to 0.
- Top-level contains the counters, the decode logic and the instance of sync_delay_line.

## Test plan
- Reset held 10 clocks, then released:
  - during reset, hs=1, vs=1, de=0, pix_x=0, pix_y=0;
  - de rises exactly PIPE_DLY clocks after release (2 at default).
- Run one line: pix_x steps 0..799 then returns to 0, and pix_y increments 0→1 on the same edge. Under default parameters:
  - hs goes low at clock 656+2 after release and stays low for 96 clocks;
  - de is high for 640 consecutive clocks.
- Run one full frame:
  - sof pulses are 420000 clocks apart;
  - vs is low for 1600 clocks, starting when pix_y reaches 490 (plus PIPE_DLY);
  - de is never high while pix_y >= 480 (accounting for PIPE_DLY).
- Wrap corner: at (799,524) the next edge gives (0,0) with sof=1. de stays 0 across the boundary until PIPE_DLY clocks after (0,0).
- Assert rst asynchronously at (300,200), mid-edge:
  - counters read 0 immediately, without waiting for clk;
  - hs=1, vs=1, de=0 immediately;
  - after release, timing matches the first scenario.
- Rebuild with SYNC_POL=1 and PIPE_DLY=4:
  - hs is high over h 656..751, delayed by 4 clocks;
  - during reset, hs=0 and vs=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60Hz VGA timing constants, counter width and sync payload type.
// Reused by the maze renderer for coordinate widths.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Raw raster controls carried through the renderer-alignment delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  localparam int unsigned SYNC_W = $bits(sync_bits_t);

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Parameterised shift register with a per-bit reset value.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, loads RST_VAL into every stage
//   i_d  - WIDTH-bit input sampled every edge
//   o_q  - input delayed by DEPTH clocks
module sync_delay_line #(
  parameter int unsigned       WIDTH   = 3,
  parameter int unsigned       DEPTH   = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  // Stage 0 captures the input; each later stage takes its predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, pixel request and
// start-of-frame decode, and sync/enable delayed to match renderer latency.
// Ports:
//   clk     - pixel clock (25 MHz)
//   rst     - asynchronous active-high reset
//   pix_x   - horizontal count, undelayed
//   pix_y   - vertical count, undelayed
//   pix_req - visible-area pixel request, undelayed (combinational)
//   sof     - start-of-frame, high while (0,0) is held (combinational)
//   hs      - horizontal sync, delayed PIPE_DLY clocks
//   vs      - vertical sync, delayed PIPE_DLY clocks
//   de      - display enable, delayed PIPE_DLY clocks
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  output logic             sof,
  output logic             hs,
  output logic             vs,
  output logic             de
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  localparam logic [SYNC_W-1:0] SYNC_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

  // Configuration guards.
  if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY must be in 1..4");
  end
  if (H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_bad_totals
    $error("vga_timing_gen: line or frame total exceeds counter width");
  end

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  sync_bits_t       w_raw;
  logic [SYNC_W-1:0] w_dly;
  sync_bits_t       w_dly_s;

  assign w_h_wrap = (r_h_cnt == CNT_W'(H_TOTAL - 1));
  assign w_v_wrap = (r_v_cnt == CNT_W'(V_TOTAL - 1));

  // Raster counters; the vertical count only moves on the end-of-line edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  assign pix_x   = r_h_cnt;
  assign pix_y   = r_v_cnt;
  assign pix_req = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
  assign sof     = (r_h_cnt == '0) && (r_v_cnt == '0);

  // Undelayed sync/enable decode at the configured active level.
  always_comb begin
    w_raw.hs = ~SYNC_POL;
    w_raw.vs = ~SYNC_POL;
    w_raw.de = pix_req;
    if ((r_h_cnt >= CNT_W'(HS_FIRST)) && (r_h_cnt <= CNT_W'(HS_LAST))) begin
      w_raw.hs = SYNC_POL;
    end
    if ((r_v_cnt >= CNT_W'(VS_FIRST)) && (r_v_cnt <= CNT_W'(VS_LAST))) begin
      w_raw.vs = SYNC_POL;
    end
  end

  // Align sync/enable with the renderer's pipelined colour output.
  sync_delay_line #(
    .WIDTH   (SYNC_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_RST)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .i_d (w_raw),
    .o_q (w_dly)
  );

  assign w_dly_s = w_dly;
  assign hs      = w_dly_s.hs;
  assign vs      = w_dly_s.vs;
  assign de      = w_dly_s.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a
// shrunken-raster instance (SYNC_POL=1, PIPE_DLY=4) compared every cycle
// against an arithmetic raster model, plus hand-computed literal checks.
module tb_vga_timing_gen;

  // Default instance parameters
  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_POL = 0, A_D = 2;
  // Small-raster instance parameters (line 25 clocks, frame 375 clocks)
  localparam int B_HA = 16, B_HF = 2, B_HS = 3, B_HB = 4;
  localparam int B_VA = 8,  B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_POL = 1, B_D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_req, a_sof, a_hs, a_vs, a_de;
  logic b_req, b_sof, b_hs, b_vs, b_de;

  int errors = 0;
  int checks = 0;
  int k;  // clock edges since the last reset release

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .pix_x(a_x), .pix_y(a_y), .pix_req(a_req),
    .sof(a_sof), .hs(a_hs), .vs(a_vs), .de(a_de)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_DLY(4)
  ) u_b (
    .clk(clk), .rst(rst), .pix_x(b_x), .pix_y(b_y), .pix_req(b_req),
    .sof(b_sof), .hs(b_hs), .vs(b_vs), .de(b_de)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, k=%0d)", name, act, exp, $time, k);
    end
  endtask

  // Raster model: outputs after n edges since release follow from position
  // n mod frame; delayed outputs look back d edges, reset values before that.
  function automatic void model(input int n, input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                input int pol, input int d,
                                output int x, output int y, output int req, output int sf,
                                output int hs, output int vs, output int de);
    int ht, vt, m, mx, my;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    x   = (n % (ht * vt)) % ht;
    y   = (n % (ht * vt)) / ht;
    req = (x < ha && y < va) ? 1 : 0;
    sf  = (x == 0 && y == 0) ? 1 : 0;
    if (n < d) begin
      hs = 1 - pol;
      vs = 1 - pol;
      de = 0;
    end else begin
      m  = (n - d) % (ht * vt);
      mx = m % ht;
      my = m / ht;
      hs = (mx >= ha + hf && mx < ha + hf + hsw) ? pol : 1 - pol;
      vs = (my >= va + vf && my < va + vf + vsw) ? pol : 1 - pol;
      de = (mx < ha && my < va) ? 1 : 0;
    end
  endfunction

  task automatic cmp_inst(input string tag, input int ha, hf, hsw, hb, va, vf, vsw, vb,
                          input int pol, input int d,
                          input int ax, ay, areq, asof, ahs, avs, ade);
    int x, y, req, sf, hs, vs, de;
    model(k, ha, hf, hsw, hb, va, vf, vsw, vb, pol, d, x, y, req, sf, hs, vs, de);
    chk({tag, ".pix_x"},   ax,   x);
    chk({tag, ".pix_y"},   ay,   y);
    chk({tag, ".pix_req"}, areq, req);
    chk({tag, ".sof"},     asof, sf);
    chk({tag, ".hs"},      ahs,  hs);
    chk({tag, ".vs"},      avs,  vs);
    chk({tag, ".de"},      ade,  de);
  endtask

  // Advance to the next falling edge and compare both instances to the model.
  task automatic step();
    @(negedge clk);
    cmp_inst("A", A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_POL, A_D,
             int'(a_x), int'(a_y), int'(a_req), int'(a_sof), int'(a_hs), int'(a_vs), int'(a_de));
    cmp_inst("B", B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_POL, B_D,
             int'(b_x), int'(b_y), int'(b_req), int'(b_sof), int'(b_hs), int'(b_vs), int'(b_de));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " A.pix_x"}, int'(a_x), 0);
    chk({tag, " A.pix_y"}, int'(a_y), 0);
    chk({tag, " A.hs"},    int'(a_hs), 1);
    chk({tag, " A.vs"},    int'(a_vs), 1);
    chk({tag, " A.de"},    int'(a_de), 0);
    chk({tag, " A.sof"},   int'(a_sof), 1);
    chk({tag, " B.pix_x"}, int'(b_x), 0);
    chk({tag, " B.hs"},    int'(b_hs), 0);
    chk({tag, " B.vs"},    int'(b_vs), 0);
    chk({tag, " B.de"},    int'(b_de), 0);
  endtask

  initial begin
    int a_hs_low, a_de_high, b_vs_act, b_sof_first, b_sof_second;
    a_hs_low = 0; a_de_high = 0; b_vs_act = 0; b_sof_first = -1; b_sof_second = -1;

    // Reset held 10 clocks
    repeat (10) step();
    check_reset_values("reset");
    #1 rst = 1'b0;

    // Two lines of A and several frames of B after release
    for (int c = 1; c <= 2000; c++) begin
      step();
      if (c <= 800 && a_hs == 1'b0) a_hs_low++;
      if (c <= 800 && a_de == 1'b1) a_de_high++;
      if (c <= 375 && b_vs == 1'b1) b_vs_act++;
      if (b_sof == 1'b1) begin
        if (b_sof_first < 0) b_sof_first = c;
        else if (b_sof_second < 0) b_sof_second = c;
      end
      if (c == 1)   chk("A.de one clk after release", int'(a_de), 0);
      if (c == 2)   chk("A.de two clks after release", int'(a_de), 1);
      if (c == 657) chk("A.hs before sync", int'(a_hs), 1);
      if (c == 658) chk("A.hs sync start", int'(a_hs), 0);
      if (c == 753) chk("A.hs sync last", int'(a_hs), 0);
      if (c == 754) chk("A.hs sync end", int'(a_hs), 1);
      if (c == 799) chk("A.pix_x end of line", int'(a_x), 799);
      if (c == 800) begin
        chk("A.pix_x wrap", int'(a_x), 0);
        chk("A.pix_y step", int'(a_y), 1);
      end
      if (c == 21)  chk("B.hs before sync", int'(b_hs), 0);
      if (c == 22)  chk("B.hs sync start", int'(b_hs), 1);
      if (c == 24)  chk("B.hs sync last", int'(b_hs), 1);
      if (c == 25)  chk("B.hs sync end", int'(b_hs), 0);
      if (c == 374) begin
        chk("B.pix_x frame end", int'(b_x), 24);
        chk("B.pix_y frame end", int'(b_y), 14);
      end
      if (c == 375) begin
        chk("B.pix_x frame wrap", int'(b_x), 0);
        chk("B.pix_y frame wrap", int'(b_y), 0);
        chk("B.sof frame wrap", int'(b_sof), 1);
      end
      if (c == 376) chk("B.sof one clk wide", int'(b_sof), 0);
      if (c == 378) chk("B.de before delayed origin", int'(b_de), 0);
      if (c == 379) chk("B.de at delayed origin", int'(b_de), 1);
    end
    chk("A.hs low clocks in line", a_hs_low, 96);
    chk("A.de high clocks in line", a_de_high, 640);
    chk("B.vs active clocks in frame", b_vs_act, 50);
    chk("B.sof spacing", b_sof_second - b_sof_first, 375);

    // Asynchronous reset mid-line, away from any clock edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async reset");
    repeat (3) step();
    #1 rst = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (c == 1) chk("A.de re-release +1", int'(a_de), 0);
      if (c == 2) chk("A.de re-release +2", int'(a_de), 1);
      if (c == 3) chk("B.de re-release +3", int'(b_de), 0);
      if (c == 4) chk("B.de re-release +4", int'(b_de), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
